// File: rtl/stream_fair_mux_pkg.sv
// Shared widths and bit-vector helpers for stream_fair_mux.
// Vectors are zero-extended to MAX_INPUTS so one helper serves every NUM_INPUTS.
package stream_fair_mux_pkg;

  localparam int MAX_INPUTS = 64;
  localparam int MAX_SELW   = 6;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Isolates the lowest set bit; bit 0 therefore has the highest priority.
  function automatic logic [MAX_INPUTS-1:0] lowest_set(input logic [MAX_INPUTS-1:0] v);
    return v & (~v + MAX_INPUTS'(1));
  endfunction

  function automatic logic [MAX_SELW-1:0] onehot_to_idx(input logic [MAX_INPUTS-1:0] oh);
    logic [MAX_SELW-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_INPUTS; i++) begin
      if (oh[i]) idx = idx | MAX_SELW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/stream_fair_mux_if.sv
// Stream bundle between N producers, the fair mux and one consumer.
// Every valid/ready pair: payload moves on a cycle where both are high; valid, once raised, holds with stable data until then.
interface stream_fair_mux_if import stream_fair_mux_pkg::*; #(
  parameter int NUM_INPUTS     = 4,
  parameter int DATAW          = 32,
  parameter int LOG_NUM_INPUTS = sel_width(NUM_INPUTS)
) ();

  logic [NUM_INPUTS-1:0]       valid_in;
  logic [NUM_INPUTS*DATAW-1:0] data_in;
  logic [NUM_INPUTS-1:0]       ready_in;
  logic                        valid_out;
  logic [DATAW-1:0]            data_out;
  logic [LOG_NUM_INPUTS-1:0]   sel_out;
  logic                        ready_out;

  modport slave (
    input  valid_in, data_in, ready_out,
    output ready_in, valid_out, data_out, sel_out
  );

  modport master (
    output valid_in, data_in, ready_out,
    input  ready_in, valid_out, data_out, sel_out
  );

endinterface

// File: rtl/stream_skid_buf.sv
// Two-entry output buffer (primary + skid) used by stream_fair_mux when STREAM_FAIR_MUX_OUT_BUF_EN is defined.
// o_ready depends only on the skid register, so upstream never sees i_ready combinationally.
module stream_skid_buf #(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  input  logic         i_ready
);

  logic         r_p_valid;
  logic [W-1:0] r_p_data;
  logic         r_s_valid;
  logic [W-1:0] r_s_data;
  logic         w_push;
  logic         w_pop;

  assign o_ready = !r_s_valid;
  assign o_valid = r_p_valid;
  assign o_data  = r_p_data;
  assign w_push  = i_valid && o_ready;
  assign w_pop   = r_p_valid && i_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_p_valid <= 1'b0;
      r_p_data  <= '0;
      r_s_valid <= 1'b0;
      r_s_data  <= '0;
    end else if (!r_p_valid || w_pop) begin
      // Skid is only ever occupied behind a full primary, so it refills first.
      if (r_s_valid) begin
        r_p_valid <= 1'b1;
        r_p_data  <= r_s_data;
        r_s_valid <= 1'b0;
      end else begin
        r_p_valid <= w_push;
        if (w_push) r_p_data <= i_data;
      end
    end else if (w_push) begin
      r_s_valid <= 1'b1;
      r_s_data  <= i_data;
    end
  end

endmodule

// File: rtl/stream_fair_mux.sv
// Round-fair N:1 valid/ready stream mux with grant locking under back-pressure.
// Define STREAM_FAIR_MUX_OUT_BUF_EN to register the output through a 2-entry skid buffer.
module stream_fair_mux import stream_fair_mux_pkg::*; #(
  parameter int NUM_INPUTS     = 4,
  parameter int DATAW          = 32,
  parameter int LOG_NUM_INPUTS = sel_width(NUM_INPUTS)
) (
  input  logic             clk,
  input  logic             reset,
  stream_fair_mux_if.slave bus
);

  logic                      w_stage_rdy;
  logic                      w_valid;
  logic [DATAW-1:0]          w_data;
  logic [LOG_NUM_INPUTS-1:0] w_sel;
  logic [NUM_INPUTS-1:0]     w_ready_in;

  assign bus.ready_in = w_ready_in;

  if (NUM_INPUTS == 1) begin : g_single
    assign w_valid    = bus.valid_in[0];
    assign w_data     = bus.data_in[DATAW-1:0];
    assign w_sel      = '0;
    assign w_ready_in = w_stage_rdy;
  end else begin : g_multi
    logic [NUM_INPUTS-1:0]     r_round_mask;
    logic                      r_use_round;
    logic                      r_lock_valid;
    logic [LOG_NUM_INPUTS-1:0] r_lock_idx;
    logic [NUM_INPUTS-1:0]     w_masked;
    logic [NUM_INPUTS-1:0]     w_eligible;
    logic [NUM_INPUTS-1:0]     w_low_oh;
    logic [LOG_NUM_INPUTS-1:0] w_grant_idx;
    logic [NUM_INPUTS-1:0]     w_grant_oh;
    logic                      w_any;
    logic                      w_take;

    always_comb begin
      w_masked    = r_round_mask & bus.valid_in;
      // An empty masked set means the round is finished (or withdrawn): restart it.
      w_eligible  = (r_use_round && (|w_masked)) ? w_masked : bus.valid_in;
      w_low_oh    = NUM_INPUTS'(lowest_set(MAX_INPUTS'(w_eligible)));
      w_grant_idx = r_lock_valid ? r_lock_idx
                                 : LOG_NUM_INPUTS'(onehot_to_idx(MAX_INPUTS'(w_low_oh)));
      w_grant_oh  = NUM_INPUTS'(1) << w_grant_idx;
      w_any       = |w_eligible;
      w_ready_in  = (w_any && w_stage_rdy) ? w_grant_oh : '0;
      w_take      = |(bus.valid_in & w_ready_in);
      w_valid     = w_any;
      w_sel       = w_grant_idx;
      w_data      = bus.data_in[int'(w_grant_idx)*DATAW +: DATAW];
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        r_round_mask <= '0;
        r_use_round  <= 1'b0;
        r_lock_valid <= 1'b0;
        r_lock_idx   <= '0;
      end else if (w_take) begin
        r_round_mask <= w_eligible & ~w_grant_oh;
        r_use_round  <= |(w_eligible & ~w_grant_oh);
        r_lock_valid <= 1'b0;
      end else if (w_any && !w_stage_rdy) begin
        // Freeze the presented grant so a late lower-index requester cannot steal it.
        r_lock_valid <= 1'b1;
        r_lock_idx   <= w_grant_idx;
      end
    end
  end

`ifdef STREAM_FAIR_MUX_OUT_BUF_EN
  logic                            w_fire;
  logic [DATAW+LOG_NUM_INPUTS-1:0] w_buf_out;

  assign w_fire = |(bus.valid_in & w_ready_in);
  assign {bus.sel_out, bus.data_out} = w_buf_out;

  stream_skid_buf #(.W(DATAW+LOG_NUM_INPUTS)) u_skid_buf (
    .clk     (clk),
    .reset   (reset),
    .i_valid (w_fire),
    .i_data  ({w_sel, w_data}),
    .o_ready (w_stage_rdy),
    .o_valid (bus.valid_out),
    .o_data  (w_buf_out),
    .i_ready (bus.ready_out)
  );
`else
  assign w_stage_rdy   = bus.ready_out;
  assign bus.valid_out = w_valid;
  assign bus.data_out  = w_data;
  assign bus.sel_out   = w_sel;
`endif

endmodule

// File: tb/tb_stream_fair_mux.sv
// Bench for stream_fair_mux: per-channel producer queues, expected-order scoreboard, one task per scenario.
// Works in both the pass-through and the STREAM_FAIR_MUX_OUT_BUF_EN build.
module tb_stream_fair_mux;

  localparam int N    = 4;
  localparam int DW   = 32;
  localparam int LOGN = 2;
  localparam int W    = LOGN + DW;
`ifdef STREAM_FAIR_MUX_OUT_BUF_EN
  localparam int EXP_STALL_ACC = 2;
`else
  localparam int EXP_STALL_ACC = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stream_fair_mux_if #(.NUM_INPUTS(N), .DATAW(DW), .LOG_NUM_INPUTS(LOGN)) u_if ();

  stream_fair_mux #(.NUM_INPUTS(N), .DATAW(DW), .LOG_NUM_INPUTS(LOGN)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  int total = 0;
  int bad   = 0;
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  got_w;
  logic [W-1:0]  exp_w;
  logic [DW-1:0] chan_data[N][16];
  int            chan_head[N];
  int            chan_tail[N];
  int            exp_rd[N];
  int            acc_count;
  logic [N-1:0]  s_ready_in;
  logic          s_valid_out;
  logic [LOGN-1:0] s_sel_out;
`ifdef STREAM_FAIR_MUX_OUT_BUF_EN
  logic [DW-1:0] s_data_out;
`endif

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!reset) begin
      total++;
      if (!$onehot0(u_if.ready_in)) begin
        bad++;
        $display("FAIL ready_onehot: ready_in=%b, required one-hot or zero", u_if.ready_in);
      end
      if (u_if.valid_out && u_if.ready_out) begin
        total++;
        got_w = {u_if.sel_out, u_if.data_out};
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_extra: got sel=%0d data=%h, required no output", u_if.sel_out, u_if.data_out);
        end else begin
          exp_w = exp_q.pop_front();
          if (got_w !== exp_w) begin
            bad++;
            $display("FAIL sb_order: got sel=%0d data=%h, required sel=%0d data=%h",
                     got_w[W-1:DW], got_w[DW-1:0], exp_w[W-1:DW], exp_w[DW-1:0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic bit pending();
    bit p = 1'b0;
    for (int i = 0; i < N; i++) if (chan_head[i] != chan_tail[i]) p = 1'b1;
    return p;
  endfunction

  task automatic apply_inputs();
    for (int i = 0; i < N; i++) begin
      if (chan_head[i] != chan_tail[i]) begin
        u_if.valid_in[i]         = 1'b1;
        u_if.data_in[i*DW +: DW] = chan_data[i][chan_head[i] % 16];
      end else begin
        u_if.valid_in[i]         = 1'b0;
        u_if.data_in[i*DW +: DW] = '0;
      end
    end
  endtask

  task automatic clear_chans();
    for (int i = 0; i < N; i++) begin
      chan_head[i] = 0;
      chan_tail[i] = 0;
      exp_rd[i]    = 0;
    end
    apply_inputs();
  endtask

  task automatic load(input int ch);
    chan_data[ch][chan_tail[ch] % 16] = DW'($urandom_range(32'h7fff_ffff, 0));
    chan_tail[ch]++;
  endtask

  task automatic expect_ch(input int ch);
    exp_q.push_back({LOGN'(ch), chan_data[ch][exp_rd[ch] % 16]});
    exp_rd[ch]++;
  endtask

  task automatic cycle();
    logic [N-1:0] acc;
    @(negedge clk);
    s_ready_in  = u_if.ready_in;
    s_valid_out = u_if.valid_out;
    s_sel_out   = u_if.sel_out;
`ifdef STREAM_FAIR_MUX_OUT_BUF_EN
    s_data_out  = u_if.data_out;
`endif
    acc = u_if.valid_in & u_if.ready_in;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        chan_head[i]++;
        acc_count++;
      end
    end
    apply_inputs();
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || pending()) && n < budget) begin
      cycle();
      n++;
    end
    total++;
    if (exp_q.size() != 0 || pending()) begin
      bad++;
      $display("FAIL %s_drain: %0d outputs still expected after %0d cycles, required 0", name, exp_q.size(), budget);
      exp_q.delete();
      clear_chans();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    cycle();
    total++;
    if (s_valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid_out: got %b, required 0", s_valid_out); end
    total++;
    if (s_ready_in !== '0) begin bad++; $display("FAIL reset_ready_in: got %b, required 0000", s_ready_in); end
    total++;
    if (s_sel_out !== '0) begin bad++; $display("FAIL reset_sel_out: got %0d, required 0", s_sel_out); end
`ifdef STREAM_FAIR_MUX_OUT_BUF_EN
    total++;
    if (s_data_out !== '0) begin bad++; $display("FAIL reset_data_out: got %h, required 0", s_data_out); end
`endif
  endtask

  task automatic test_round_fairness();
    clear_chans();
    u_if.ready_out = 1'b1;
    for (int r = 0; r < 2; r++) for (int c = 0; c < N; c++) load(c);
    for (int r = 0; r < 2; r++) for (int c = 0; c < N; c++) expect_ch(c);
    apply_inputs();
    drain("round_fairness", 40);
  endtask

  task automatic test_late_arrival();
    clear_chans();
    u_if.ready_out = 1'b1;
    load(2); load(3);
    expect_ch(2); expect_ch(3);
    apply_inputs();
    cycle();
    total++;
    if (chan_head[2] !== 1 || chan_head[3] !== 0) begin
      bad++;
      $display("FAIL late_first_grant: accepted ch2=%0d ch3=%0d, required ch2=1 ch3=0", chan_head[2], chan_head[3]);
    end
    load(0);
    expect_ch(0);
    apply_inputs();
    drain("late_arrival", 20);
  endtask

  task automatic test_lock_stall();
    clear_chans();
    u_if.ready_out = 1'b0;
    load(2);
    expect_ch(2);
    apply_inputs();
    cycle(); cycle();
    load(0);
    expect_ch(0);
    apply_inputs();
    cycle(); cycle();
    total++;
    if (s_ready_in !== '0) begin bad++; $display("FAIL lock_ready_in: got %b, required 0000", s_ready_in); end
    total++;
    if (s_sel_out !== 2'd2) begin bad++; $display("FAIL lock_sel_out: got %0d, required 2", s_sel_out); end
    total++;
    if (s_valid_out !== 1'b1) begin bad++; $display("FAIL lock_valid_out: got %b, required 1", s_valid_out); end
    u_if.ready_out = 1'b1;
    drain("lock_stall", 20);
  endtask

  task automatic test_withdrawn_round();
    clear_chans();
    u_if.ready_out = 1'b1;
    load(1); load(3);
    expect_ch(1);
    apply_inputs();
    cycle();
    total++;
    if (chan_head[1] !== 1) begin bad++; $display("FAIL withdraw_first: ch1 accepted=%0d, required 1", chan_head[1]); end
    chan_head[3] = chan_tail[3];
    exp_rd[3]    = chan_tail[3];
    load(1);
    expect_ch(1);
    apply_inputs();
    drain("withdrawn_round", 20);
  endtask

  task automatic test_back_pressure();
    clear_chans();
    u_if.ready_out = 1'b0;
    load(0); load(0); load(1); load(2); load(3);
    expect_ch(0); expect_ch(1); expect_ch(2); expect_ch(3); expect_ch(0);
    apply_inputs();
    acc_count = 0;
    repeat (3) cycle();
    total++;
    if (acc_count !== EXP_STALL_ACC) begin
      bad++;
      $display("FAIL stall_accepts: got %0d, required %0d", acc_count, EXP_STALL_ACC);
    end
    total++;
    if (s_ready_in !== '0) begin bad++; $display("FAIL stall_ready_in: got %b, required 0000", s_ready_in); end
    u_if.ready_out = 1'b1;
    drain("back_pressure", 30);
  endtask

  task automatic test_reset_midflow();
    clear_chans();
    u_if.ready_out = 1'b1;
    for (int c = 0; c < N; c++) load(c);
    expect_ch(0);
    apply_inputs();
    cycle();
    u_if.ready_out = 1'b0;
    cycle(); cycle();
    reset = 1'b1;
    clear_chans();
    exp_q.delete();
    cycle();
    reset = 1'b0;
    cycle();
    total++;
    if (s_valid_out !== 1'b0) begin bad++; $display("FAIL midreset_valid_out: got %b, required 0", s_valid_out); end
    total++;
    if (s_ready_in !== '0) begin bad++; $display("FAIL midreset_ready_in: got %b, required 0000", s_ready_in); end
    u_if.ready_out = 1'b1;
    for (int c = 0; c < N; c++) load(c);
    for (int c = 0; c < N; c++) expect_ch(c);
    apply_inputs();
    drain("reset_restart", 20);
  endtask

  // ---------------- clock/reset and sequence ----------------
  initial begin
    reset          = 1'b1;
    u_if.valid_in  = '0;
    u_if.data_in   = '0;
    u_if.ready_out = 1'b0;
    acc_count      = 0;
    for (int i = 0; i < N; i++) begin
      chan_head[i] = 0;
      chan_tail[i] = 0;
      exp_rd[i]    = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    test_reset();
    test_round_fairness();
    test_late_arrival();
    test_lock_stall();
    test_withdrawn_round();
    test_back_pressure();
    test_reset_midflow();
    repeat (3) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
